// File: rtl/collect_data_stream.sv
// Serial-record parser: UART bytes -> (address, payload) write commands for the screen RAM.
// Define COLLECT_BURST_EN to keep writing consecutive addresses after each payload group.
module collect_data_stream #(
  parameter int         ADDR_W        = 13,
  parameter int         PAYLOAD_BYTES = 2,
  parameter logic [7:0] SYNC_BYTE     = 8'hFF,
  parameter int         TIMEOUT_CYC   = 50000
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       computer_running,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [8*PAYLOAD_BYTES-1:0] wr_data,
  output logic                       busy,
  output logic                       timeout_err
);
  localparam int ADDR_BYTES = (ADDR_W + 6) / 7;
  localparam int DATA_W     = 8 * PAYLOAD_BYTES;
  localparam int MAX_BYTES  = (ADDR_BYTES > PAYLOAD_BYTES) ? ADDR_BYTES : PAYLOAD_BYTES;
  localparam int IDX_W      = $clog2(MAX_BYTES + 1);
  localparam int TMR_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_BYTES - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(PAYLOAD_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [0:0] {ST_ADDR = 1'b0, ST_DATA = 1'b1} state_t;

  state_t            state_r, state_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic [TMR_W-1:0]  tmr_r, tmr_s;
  logic [ADDR_W-1:0] addr_sh_r, addr_sh_s;
  logic [DATA_W-1:0] data_sh_r, data_sh_s;
  logic              grp_r, grp_s;  // burst: a group was written since the last address
  logic              busy_now_s, busy_s, wr_en_s, timeout_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;

  // Next-state, shadow and output computation
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    tmr_s     = tmr_r;
    addr_sh_s = addr_sh_r;
    data_sh_s = data_sh_r;
    grp_s     = grp_r;
    wr_en_s   = 1'b0;
    timeout_s = 1'b0;
    wr_addr_s = wr_addr;
    wr_data_s = wr_data;
    if (state_r == ST_ADDR) begin
      busy_now_s = (idx_r != '0);
    end else begin
      busy_now_s = !(grp_r && (idx_r == '0));
    end

    if (!computer_running) begin
      state_s = ST_ADDR;
      idx_s   = '0;
      tmr_s   = '0;
      grp_s   = 1'b0;
    end else if (rx_valid) begin
      tmr_s = '0;
      if (rx_data == SYNC_BYTE) begin
        state_s = ST_ADDR;
        idx_s   = '0;
        grp_s   = 1'b0;
      end else begin
        case (state_r)
          ST_ADDR: begin
            addr_sh_s = ADDR_W'({addr_sh_r, rx_data[6:0]});
            if (idx_r == ADDR_LAST) begin
              state_s = ST_DATA;
              idx_s   = '0;
            end else begin
              idx_s = idx_r + IDX_W'(1);
            end
          end
          ST_DATA: begin
            data_sh_s = DATA_W'({data_sh_r, rx_data});
            if (idx_r == DATA_LAST) begin
              wr_en_s   = 1'b1;
              wr_addr_s = addr_sh_r;
              wr_data_s = data_sh_s;
              idx_s     = '0;
`ifdef COLLECT_BURST_EN
              addr_sh_s = addr_sh_r + ADDR_W'(1);
              grp_s     = 1'b1;
              state_s   = ST_DATA;
`else
              state_s   = ST_ADDR;
`endif
            end else begin
              idx_s = idx_r + IDX_W'(1);
            end
          end
          default: begin
            state_s = ST_ADDR;
            idx_s   = '0;
            grp_s   = 1'b0;
          end
        endcase
      end
    end else if (busy_now_s) begin
      if (tmr_r == TMR_LAST) begin
        state_s   = ST_ADDR;
        idx_s     = '0;
        tmr_s     = '0;
        grp_s     = 1'b0;
        timeout_s = 1'b1;
      end else begin
        tmr_s = tmr_r + TMR_W'(1);
      end
    end else begin
      tmr_s = '0;
    end

    if (state_s == ST_ADDR) begin
      busy_s = (idx_s != '0);
    end else begin
      busy_s = !(grp_s && (idx_s == '0));
    end
  end

  // State register and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_ADDR;
      idx_r       <= '0;
      tmr_r       <= '0;
      addr_sh_r   <= '0;
      data_sh_r   <= '0;
      grp_r       <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      tmr_r       <= tmr_s;
      addr_sh_r   <= addr_sh_s;
      data_sh_r   <= data_sh_s;
      grp_r       <= grp_s;
      wr_en       <= wr_en_s;
      wr_addr     <= wr_addr_s;
      wr_data     <= wr_data_s;
      busy        <= busy_s;
      timeout_err <= timeout_s;
    end
  end
endmodule

// File: tb/tb_collect_data_stream.sv
// Bench for collect_data_stream: record-level reference model, per-cycle compare, directed pins.
module tb_collect_data_stream;
  localparam int         AW   = 13;
  localparam int         PB   = 2;
  localparam int         DW   = 8 * PB;
  localparam int         AB   = (AW + 6) / 7;
  localparam int         TO   = 40;
  localparam logic [7:0] SYNC = 8'hFF;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          computer_running = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          timeout_err;

  collect_data_stream #(.ADDR_W(AW), .PAYLOAD_BYTES(PB), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .computer_running(computer_running), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .timeout_err(timeout_err));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int dut_wr_cnt = 0;
  int dut_to_cnt = 0;
  bit chk_en = 1'b0;

  // Reference model: bytes of the record collected so far, plus the current target address.
  logic [7:0]    abuf[$];
  logic [7:0]    dbuf[$];
  bit            have_addr = 1'b0;
  bit            grp_done = 1'b0;
  int unsigned   cur_addr = 0;
  int            idle = 0;
  logic          exp_wr_en = 1'b0;
  logic          exp_to = 1'b0;
  logic          exp_busy = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of();
    logic [63:0] v = 64'd0;
    for (int k = 0; k < AB; k++) v = v * 64'd128 + 64'(abuf[k] & 8'h7F);
    return AW'(v);
  endfunction

  function automatic logic [DW-1:0] data_of();
    logic [63:0] v = 64'd0;
    for (int k = 0; k < PB; k++) v = v * 64'd256 + 64'(dbuf[k]);
    return DW'(v);
  endfunction

  function automatic bit model_busy();
    return (abuf.size() != 0) || (have_addr && !(grp_done && dbuf.size() == 0));
  endfunction

  task automatic model_clear();
    abuf.delete();
    dbuf.delete();
    have_addr = 1'b0;
    grp_done  = 1'b0;
  endtask

  task automatic model_step();
    exp_wr_en = 1'b0;
    exp_to    = 1'b0;
    if (!computer_running) begin
      model_clear();
      idle = 0;
    end else if (rx_valid) begin
      idle = 0;
      if (rx_data == SYNC) begin
        model_clear();
      end else if (!have_addr) begin
        abuf.push_back(rx_data);
        if (abuf.size() == AB) begin
          cur_addr  = int'(addr_of());
          abuf.delete();
          have_addr = 1'b1;
          grp_done  = 1'b0;
        end
      end else begin
        dbuf.push_back(rx_data);
        if (dbuf.size() == PB) begin
          exp_wr_en = 1'b1;
          exp_addr  = AW'(cur_addr);
          exp_data  = data_of();
          dbuf.delete();
`ifdef COLLECT_BURST_EN
          cur_addr = (cur_addr + 1) % (1 << AW);
          grp_done = 1'b1;
`else
          have_addr = 1'b0;
`endif
        end
      end
    end else if (model_busy()) begin
      idle++;
      if (idle == TO) begin
        model_clear();
        idle   = 0;
        exp_to = 1'b1;
      end
    end else begin
      idle = 0;
    end
    exp_busy = model_busy();
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic run);
    rx_valid = v;
    rx_data = d;
    computer_running = run;
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, d, 1'b1);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1);
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clock) begin
    if (chk_en) begin
      check("wr_en", 32'(wr_en), 32'(exp_wr_en));
      check("timeout_err", 32'(timeout_err), 32'(exp_to));
      check("busy", 32'(busy), 32'(exp_busy));
      check("wr_addr", 32'(wr_addr), 32'(exp_addr));
      check("wr_data", 32'(wr_data), 32'(exp_data));
      if (wr_en === 1'b1) dut_wr_cnt++;
      if (timeout_err === 1'b1) dut_to_cnt++;
    end
  end

  initial begin
    int w0;
    int t0;
    repeat (3) @(negedge clock);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    resetn = 1'b1;
    #1 chk_en = 1'b1;

    // Record aborted by SYNC, then a clean record
    w0 = dut_wr_cnt;
    send(SYNC); send(8'h12); send(8'h05); send(8'h41); send(SYNC);
    send(8'h00); send(8'h10); send(8'h42); send(8'h07);
    idle_n(2);
    #1;
    check("t2_writes", 32'(dut_wr_cnt - w0), 32'd1);
    check("t2_addr", 32'(wr_addr), 32'h010);
    check("t2_data", 32'(wr_data), 32'h4207);
    check("t2_model_addr", 32'(exp_addr), 32'h010);

    // Timeout mid-record, then a long idle line with nothing in progress
    w0 = dut_wr_cnt;
    t0 = dut_to_cnt;
    send(SYNC); send(8'h12); send(8'h05);
    idle_n(TO - 1);
    #1 check("t3_before_expiry", 32'(dut_to_cnt - t0), 32'd0);
    idle_n(1);
    #1;
    check("t3_timeout", 32'(dut_to_cnt - t0), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    idle_n(2 * TO);
    #1;
    check("t3_idle_no_timeout", 32'(dut_to_cnt - t0), 32'd1);
    check("t3_no_write", 32'(dut_wr_cnt - w0), 32'd0);

    // Byte arriving in the expiry cycle is taken, not an error
    w0 = dut_wr_cnt;
    t0 = dut_to_cnt;
    send(SYNC); send(8'h12); idle_n(TO - 1);
    send(8'h05); send(8'h41); send(8'h1E);
    idle_n(1);
    #1;
    check("tx_expiry_no_err", 32'(dut_to_cnt - t0), 32'd0);
    check("tx_expiry_write", 32'(dut_wr_cnt - w0), 32'd1);
    check("tx_expiry_data", 32'(wr_data), 32'h411E);

    // computer_running low mid-record discards it and ignores bytes
    w0 = dut_wr_cnt;
    send(SYNC); send(8'h12); send(8'h05); send(8'h41);
    cyc(1'b1, 8'h33, 1'b0); cyc(1'b1, 8'h44, 1'b0); cyc(1'b0, 8'h00, 1'b0);
    send(8'h00); send(8'h01); send(8'h58); send(8'h0F);
    idle_n(1);
    #1;
    check("t4_writes", 32'(dut_wr_cnt - w0), 32'd1);
    check("t4_addr", 32'(wr_addr), 32'h001);
    check("t4_data", 32'(wr_data), 32'h580F);

    // Back-to-back bytes across a record boundary (address wrap in burst mode)
    w0 = dut_wr_cnt;
    send(SYNC); send(8'h3F); send(8'h7F); send(8'h41); send(8'h01); send(8'h42); send(8'h02);
    idle_n(1);
    #1;
`ifdef COLLECT_BURST_EN
    check("t5_writes", 32'(dut_wr_cnt - w0), 32'd2);
    check("t5_addr_wrap", 32'(wr_addr), 32'h0000);
    check("t5_data", 32'(wr_data), 32'h4202);
`else
    check("t6_writes", 32'(dut_wr_cnt - w0), 32'd1);
    check("t6_addr", 32'(wr_addr), 32'h1FFF);
    check("t6_data", 32'(wr_data), 32'h4101);
    check("t6_busy", 32'(busy), 32'd1);
`endif
    send(SYNC);

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      logic v;
      logic run;
      logic [7:0] d;
      if ($urandom_range(0, 149) == 0) begin
        idle_n(int'($urandom_range(TO - 3, TO + 3)));
      end
      v = ($urandom_range(0, 2) != 0);
      run = ($urandom_range(0, 99) != 0);
      d = ($urandom_range(0, 31) == 0) ? SYNC : 8'($urandom_range(0, 254));
      cyc(v, d, run);
    end
    idle_n(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
